// File: rtl/pam4_symbol_mapper_pkg.sv
// pam4_symbol_mapper_pkg: 4-PAM constellation definitions shared by mapper and detector.
package pam4_symbol_mapper_pkg;
   localparam int LVL_M3 = -3;
   localparam int LVL_M1 = -1;
   localparam int LVL_P1 = 1;
   localparam int LVL_P3 = 3;
   // Level per 2-bit field value, natural and Gray orderings
   localparam int NAT_LVL [4] = '{LVL_M3, LVL_M1, LVL_P1, LVL_P3};
   localparam int GRAY_LVL [4] = '{LVL_M3, LVL_M1, LVL_P3, LVL_P1};
   localparam int OFF_I1 = 0;
   localparam int OFF_Q1 = 2;
   localparam int OFF_I2 = 4;
   localparam int OFF_Q2 = 6;
   function automatic logic signed [63:0] lvl_word(input int k, input int q);
      return longint'(k) <<< q;
   endfunction
endpackage

// File: rtl/pam4_level_lut.sv
// pam4_level_lut: maps one 2-bit field to its signed fixed-point 4-PAM level.
module pam4_level_lut
   import pam4_symbol_mapper_pkg::*;
#(
   parameter int N    = 32,
   parameter int Q    = 22,
   parameter int GRAY = 0
) (
   input  logic [1:0]   bits,
   output logic [N-1:0] level
);
   assign level = N'(lvl_word(GRAY != 0 ? GRAY_LVL[bits] : NAT_LVL[bits], Q));
endmodule

// File: rtl/pam4_symbol_mapper.sv
// pam4_symbol_mapper: maps 8-bit symbol groups to four 4-PAM levels through a
// 2-entry output FIFO with frame delimiting and per-frame symbol count.
module pam4_symbol_mapper
   import pam4_symbol_mapper_pkg::*;
#(
   parameter int N     = 32,
   parameter int Q     = 22,
   parameter int GRAY  = 0,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [N-1:0]     xI1,
   output logic [N-1:0]     xQ1,
   output logic [N-1:0]     xI2,
   output logic [N-1:0]     xQ2,
   output logic [7:0]       out_bits,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sym_cnt
);
   localparam int W = 4 * N + 9 + CNT_W;
   logic [N-1:0] lv_i1, lv_q1, lv_i2, lv_q2;
   logic [W-1:0] mem [2];
   logic [1:0] count;
   logic wr_ptr, rd_ptr, rdy_en, push, pop;
   logic [CNT_W-1:0] wr_cnt;
   pam4_level_lut #(.N(N), .Q(Q), .GRAY(GRAY)) u_lut_i1 (.bits(in_data[OFF_I1+:2]), .level(lv_i1));
   pam4_level_lut #(.N(N), .Q(Q), .GRAY(GRAY)) u_lut_q1 (.bits(in_data[OFF_Q1+:2]), .level(lv_q1));
   pam4_level_lut #(.N(N), .Q(Q), .GRAY(GRAY)) u_lut_i2 (.bits(in_data[OFF_I2+:2]), .level(lv_i2));
   pam4_level_lut #(.N(N), .Q(Q), .GRAY(GRAY)) u_lut_q2 (.bits(in_data[OFF_Q2+:2]), .level(lv_q2));
   // rdy_en keeps in_ready low until the first edge after reset release
   assign in_ready  = rdy_en && count != 2'd2;
   assign out_valid = count != 2'd0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign {xI1, xQ1, xI2, xQ2, out_bits, out_last, sym_cnt} = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         rdy_en <= 1'b0;
         wr_cnt <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= {lv_i1, lv_q1, lv_i2, lv_q2, in_data, in_last, wr_cnt};
            wr_ptr      <= ~wr_ptr;
            wr_cnt      <= in_last ? '0 : wr_cnt + CNT_W'(1);
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: tb/tb_pam4_symbol_mapper.sv
// tb_pam4_symbol_mapper: vector table plus randomized scoreboard against an
// arithmetic level/frame model and a minimum-distance detector loopback.
module tb_pam4_symbol_mapper;
   localparam int N = 32, Q = 22, CW = 12;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic [7:0] in_data = '0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_last, g_in_ready, g_out_valid, g_out_last;
   logic [N-1:0] xi1, xq1, xi2, xq2, g_xi1, g_xq1, g_xi2, g_xq2;
   logic [7:0] out_bits, g_out_bits;
   logic [CW-1:0] sym_cnt, g_sym_cnt;

   pam4_symbol_mapper #(.N(N), .Q(Q), .GRAY(0), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .xI1(xi1), .xQ1(xq1), .xI2(xi2), .xQ2(xq2), .out_bits(out_bits),
      .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .sym_cnt(sym_cnt));
   pam4_symbol_mapper #(.N(N), .Q(Q), .GRAY(1), .CNT_W(CW)) dut_g (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(g_in_ready), .xI1(g_xi1), .xQ1(g_xq1), .xI2(g_xi2), .xQ2(g_xq2), .out_bits(g_out_bits),
      .out_last(g_out_last), .out_valid(g_out_valid), .out_ready(out_ready), .sym_cnt(g_sym_cnt));

   typedef struct {logic [7:0] bits; logic last; int cnt;} ent_t;
   typedef struct {logic [7:0] d; bit g; logic [127:0] e;} vec_t;
   ent_t sb[$];
   logic [8:0] pend[$];
   vec_t tbl[6];
   int n_cmp = 0, n_bad = 0, fcnt = 0, npop = 0, vpct = 100, rpct = 100, used;
   bit armed = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Natural: level = 2*idx-3; Gray: idx is the Gray-decoded field
   function automatic logic [31:0] lvl(input logic [1:0] b, input bit g);
      int idx;
      idx = g ? int'({b[1], b[1] ^ b[0]}) : int'(b);
      return 32'((2 * idx - 3) * (1 << Q));
   endfunction

   function automatic int det(input logic [31:0] x);
      int v;
      v = int'(signed'(x));
      return v < -(2 << Q) ? 0 : v < 0 ? 1 : v < (2 << Q) ? 2 : 3;
   endfunction

   task automatic drive();
      in_valid = pend.size() > 0 && $urandom_range(99) < vpct;
      in_data = pend.size() > 0 ? pend[0][7:0] : 8'($urandom);
      in_last = pend.size() > 0 ? pend[0][8] : 1'b0;
      out_ready = $urandom_range(99) < rpct;
   endtask

   task automatic cyc();
      ent_t e;
      @(negedge clk);
      if (armed) chk("in_ready", in_ready, sb.size() < 2);
      chk("out_valid", out_valid, sb.size() > 0);
      if (out_valid && out_ready && sb.size() > 0) begin
         e = sb.pop_front();
         chk("xI1", xi1, lvl(e.bits[1:0], 0));
         chk("xQ1", xq1, lvl(e.bits[3:2], 0));
         chk("xI2", xi2, lvl(e.bits[5:4], 0));
         chk("xQ2", xq2, lvl(e.bits[7:6], 0));
         chk("out_bits", out_bits, e.bits);
         chk("out_last", out_last, e.last);
         chk("sym_cnt", sym_cnt, e.cnt);
         chk("det_loop", {det(xq2), det(xi2), det(xq1), det(xi1)},
             {int'(e.bits[7:6]), int'(e.bits[5:4]), int'(e.bits[3:2]), int'(e.bits[1:0])});
         npop++;
      end
      if (in_valid && in_ready) begin
         sb.push_back('{in_data, in_last, fcnt});
         fcnt = in_last ? 0 : (fcnt + 1) % (1 << CW);
         void'(pend.pop_front());
      end
      @(posedge clk);
      armed = 1'b1;
      #1 drive();
   endtask

   task automatic drain(input int maxc, output int c);
      c = 0;
      while ((pend.size() > 0 || sb.size() > 0) && c < maxc) begin
         cyc();
         c++;
      end
      if (c >= maxc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d cycles, %0d pending, %0d buffered", c, pend.size(), sb.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      sb.delete();
      pend.delete();
      fcnt = 0;
      armed = 1'b0;
      #17;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{8'hE4, 1'b0, {32'hFF400000, 32'hFFC00000, 32'h00400000, 32'h00C00000}};
      tbl[1] = '{8'b10_11_01_00, 1'b1, {32'hFF400000, 32'hFFC00000, 32'h00400000, 32'h00C00000}};
      tbl[2] = '{8'h00, 1'b0, {4{32'hFF400000}}};
      tbl[3] = '{8'hFF, 1'b0, {4{32'h00C00000}}};
      tbl[4] = '{8'hFF, 1'b1, {4{32'h00400000}}};
      tbl[5] = '{8'h1B, 1'b0, {32'h00C00000, 32'h00400000, 32'hFFC00000, 32'hFF400000}};
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_levels", {xi1, xq1, xi2, xq2}, 0);
      chk("rst_misc", {out_bits, out_last, sym_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rdy_after_release", in_ready, 0);
      @(posedge clk);
      #1 chk("rdy_first_cycle", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data = tbl[i].d;
         in_last = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
         chk("tbl_valid", out_valid, 1);
         chk("tbl_levels", tbl[i].g ? {g_xi1, g_xq1, g_xi2, g_xq2} : {xi1, xq1, xi2, xq2}, tbl[i].e);
         chk("tbl_cnt", tbl[i].g ? g_sym_cnt : sym_cnt, CW'(i));
      end
      @(posedge clk);
      #1 chk("tbl_drained", out_valid, 0);
      do_reset();
      // Backpressure: three offered, two held, first presented stable
      npop = 0; vpct = 100; rpct = 0;
      for (int i = 0; i < 3; i++) pend.push_back({1'b0, 8'($urandom)});
      drive();
      repeat (4) cyc();
      chk("bp_held", sb.size(), 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_level", xi1, lvl(sb[0].bits[1:0], 0));
      chk("bp_hold_bits", out_bits, sb[0].bits);
      rpct = 100;
      drive();
      drain(50, used);
      chk("bp_count", npop, 3);
      // Streaming: one output per cycle
      npop = 0;
      for (int i = 0; i < 16; i++) pend.push_back({1'b0, 8'($urandom)});
      drive();
      drain(100, used);
      chk("stream_cycles", used, 17);
      chk("stream_count", npop, 16);
      // Back-to-back frames of 3 and 2
      vpct = 70; rpct = 70;
      for (int i = 0; i < 5; i++) pend.push_back({i == 2 || i == 4, 8'($urandom)});
      drive();
      drain(200, used);
      // Reset with two entries buffered mid-frame
      vpct = 100; rpct = 0;
      for (int i = 0; i < 4; i++) pend.push_back({1'b0, 8'($urandom)});
      drive();
      repeat (3) cyc();
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_levels", {xi1, xq1, xi2, xq2}, 0);
      chk("mid_rst_misc", {out_bits, out_last, sym_cnt}, 0);
      do_reset();
      vpct = 80; rpct = 80;
      for (int i = 0; i < 3; i++) pend.push_back({i == 2, 8'($urandom)});
      drive();
      drain(200, used);
      // Random frames, then one long frame crossing the counter wrap
      for (int i = 0; i < 200; i++) pend.push_back({$urandom_range(7) == 0, 8'($urandom)});
      drive();
      drain(2000, used);
      vpct = 90; rpct = 90;
      for (int i = 0; i < 4100; i++) pend.push_back({i == 4099, 8'($urandom)});
      drive();
      drain(20000, used);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pam4_symbol_mapper.md
Name: pam4_symbol_mapper

Overview:
Transmit-side counterpart of the 4-PAM minimum-distance detector. It accepts one 8-bit symbol group per handshake and maps each 2-bit field to a signed fixed-point level in {-3,-1,+1,+3}. The four outputs are I1, Q1, I2 and Q2 for the two transmit branches. A 2-entry output buffer sustains one symbol per cycle under valid/ready backpressure, and the block carries frame delimiting and a per-frame symbol count.

Parameters:
N, 32, sample word width (signed, two's complement)
Q, 22, fractional bits; level k is encoded as k·2^Q sign-extended to N bits
GRAY, 0, 0 = natural index mapping; 1 = Gray-coded mapping
CNT_W, 12, width of the per-frame symbol counter

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous reset, active-low
in_data  in  8  symbol bits: [1:0]=I1, [3:2]=Q1, [5:4]=I2, [7:6]=Q2
in_valid  in  1  in_data/in_last valid
in_last  in  1  final symbol of frame
in_ready  out  1  block can accept this cycle
xI1  out  N  mapped I level, branch 1
xQ1  out  N  mapped Q level, branch 1
xI2  out  N  mapped I level, branch 2
xQ2  out  N  mapped Q level, branch 2
out_bits  out  8  raw in_data of the presented symbol, for loopback compare against detector indices
out_last  out  1  frame end, aligned to the symbol
out_valid  out  1  outputs valid
out_ready  in  1  downstream accepts
sym_cnt  out  CNT_W  0-based index of the presented symbol within its frame

Behaviour:
- Reset is asynchronous on rst_n low. Buffer is emptied, in_ready=0 while rst_n low, out_valid=0, and xI1/xQ1/xI2/xQ2/out_bits/out_last/sym_cnt are all 0. in_ready rises in the first cycle after rst_n deasserts.
- Reset mid-frame discards buffered symbols and clears the frame count. No partial output is produced.
- Level mapping with GRAY=0 uses index 0,1,2,3 → -3,-1,+1,+3. This matches the detector's index order.
- Level mapping with GRAY=1 uses bits 00,01,11,10 → -3,-1,+1,+3.
- Encoded constants for N=32, Q=22: -3=32'hFF400000, -1=32'hFFC00000, +1=32'h00400000, +3=32'h00C00000. Mapping is a pure lookup with no arithmetic overflow. N must be at least Q+3.
- Input handshake: transfer occurs when in_valid && in_ready. in_ready = (count<2); it is registered-count based and does not depend combinationally on out_ready.
- Output handshake: transfer occurs when out_valid && out_ready. out_valid = (count>0).
- While out_valid=1 && out_ready=0, all outputs hold stable.
- Buffer: 2-entry FIFO of {levels, bits, last, sym_cnt}. Mapping is done before the write, so the mapped values are stored.
- Latency: a symbol accepted at edge t is presented with out_valid=1 after edge t (1 cycle) when the buffer was empty.
- Occupancy:
  - count=0: push only.
  - count=1 with push and pop in the same cycle: count stays 1, the new entry becomes head next cycle, throughput is 1 per cycle.
  - count=2: in_ready=0, pop only.
- Pointer wrap: 1-bit read and write pointers toggle modulo 2.
- Frame counter: wr_cnt increments on each accepted symbol and is stored with the entry. It clears to 0 after an accepted symbol with in_last=1.
- Counter wrap: wr_cnt wraps at 2^CNT_W with no error.
- Back-to-back frames need no idle cycle between them.
- No internal state machine beyond the FIFO occupancy (EMPTY/ONE/FULL), which is encoded by count.

Decomposition:
- Shared package holds:
  - the level constants LVL_M3, LVL_M1, LVL_P1, LVL_P3, as N-bit functions of Q;
  - the Gray/natural index tables;
  - the 2-bit field offsets for I1/Q1/I2/Q2.
  The detector side uses the same package so the constellation definitions cannot diverge.
- One natural sub-module, pam4_level_lut: combinational mapping of 2 bits + GRAY to an N-bit level, instantiated 4×.
- The FIFO is kept inline.

Test Plan:
1. Reset then a single symbol in_data=8'hE4, GRAY=0, out_ready=1 → 1 cycle later xI1=FF400000, xQ1=FFC00000, xI2=00400000, xQ2=00C00000, sym_cnt=0.
2. GRAY=1, in_data=8'b10_11_01_00 → levels -3, -1, +1, +3 on I1, Q1, I2, Q2 respectively.
3. Backpressure: 3 symbols offered with out_ready=0 → in_ready drops after 2 accepts and outputs hold the first symbol. Then out_ready=1 → all 3 symbols emerge in order, none lost or duplicated.
4. Streaming: 16 random symbols, continuous in_valid/out_ready=1 → one output per cycle, and a loopback through the detector yields indices equal to out_bits.
5. Frames: frame of 3 (in_last on the 3rd), then a frame of 2 → sym_cnt sequence 0,1,2,0,1 with out_last on symbols 3 and 5.
6. rst_n pulsed low with 2 entries buffered mid-frame → out_valid=0 immediately and all outputs 0. The next frame starts at sym_cnt=0.
